// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - request/response sequencer driving an external combinational ALU
// Single-cycle ops use one EXEC pass; multiply is 32 shift-and-add passes through the ALU adder.
module alu_ctrl #(
   parameter int MUL_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_carry,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_dout,
   input  logic        alu_cout
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_BAD = 3'b111;

   state_t      state, state_n;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] acc, mcand, mplier;
   logic [5:0]  cnt;
   logic        req_illegal;
   logic        mul_done;

   assign req_illegal = (req_op == OP_BAD) || ((req_op == OP_MUL) && (MUL_EN == 0));
   // The counter runs one step past the last iteration so acc can be copied out cleanly.
   assign mul_done    = (cnt == 6'd32);
   assign req_ready   = (state == IDLE);
   assign rsp_valid   = (state == RESP);

   always_comb begin
      state_n     = state;
      alu_a       = '0;
      alu_b       = '0;
      alu_control = 3'b000;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_illegal)
                  state_n = RESP;
               else if (req_op == OP_MUL)
                  state_n = MUL;
               else
                  state_n = EXEC;
            end
         end
         EXEC: begin
            alu_a       = a_q;
            alu_b       = b_q;
            alu_control = op_q;
            state_n     = RESP;
         end
         MUL: begin
            alu_a       = acc;
            alu_b       = mplier[0] ? mcand : '0;
            alu_control = OP_ADD;
            if (mul_done)
               state_n = RESP;
         end
         RESP: begin
            if (rsp_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         cnt       <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  a_q    <= req_a;
                  b_q    <= req_b;
                  acc    <= '0;
                  mcand  <= req_a;
                  mplier <= req_b;
                  cnt    <= '0;
                  if (req_illegal) begin
                     rsp_data  <= '0;
                     rsp_carry <= 1'b0;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            EXEC: begin
               rsp_data  <= alu_dout;
               rsp_carry <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_cout : 1'b0;
               rsp_err   <= 1'b0;
            end
            MUL: begin
               if (mul_done) begin
                  rsp_data  <= acc;
                  rsp_carry <= 1'b0;
                  rsp_err   <= 1'b0;
               end else begin
                  acc    <= alu_dout;
                  mcand  <= {mcand[30:0], 1'b0};
                  mplier <= {1'b0, mplier[31:1]};
                  cnt    <= cnt + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - directed vector bench for alu_ctrl with a behavioural ALU
// A second instance with MUL_EN=0 covers the disabled-multiply opcode.
module tb_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid2;
   logic        req_ready, req_ready2;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        rsp_valid, rsp_valid2;
   logic        rsp_ready;
   logic [31:0] rsp_data, rsp_data2;
   logic        rsp_carry, rsp_carry2;
   logic        rsp_err, rsp_err2;
   logic [31:0] alu_a, alu_b, alu_a2, alu_b2;
   logic [2:0]  alu_control, alu_control2;
   logic [31:0] alu_dout;
   logic        alu_cout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_ctrl #(.MUL_EN(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
      .alu_dout(alu_dout), .alu_cout(alu_cout)
   );

   alu_ctrl #(.MUL_EN(0)) dut2 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid2), .req_ready(req_ready2),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid2), .rsp_ready(1'b1),
      .rsp_data(rsp_data2), .rsp_carry(rsp_carry2), .rsp_err(rsp_err2),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_control(alu_control2),
      .alu_dout(32'h0), .alu_cout(1'b0)
   );

   // Reference ALU: SUB reports borrow on cout.
   always_comb begin
      alu_dout = '0;
      alu_cout = 1'b0;
      case (alu_control)
         3'b000: alu_dout = ~alu_a;
         3'b001: alu_dout = alu_a & alu_b;
         3'b010: alu_dout = $signed(alu_a) >>> alu_b[4:0];
         3'b011: alu_dout = alu_a ^ alu_b;
         3'b100: {alu_cout, alu_dout} = {1'b0, alu_a} + {1'b0, alu_b};
         3'b101: {alu_cout, alu_dout} = {1'b0, alu_a} - {1'b0, alu_b};
         default: ;
      endcase
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] data;
      logic        carry;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  lat;
      bit  mul_ctl_bad;
      @(negedge clk);
      check($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = v.op;
      req_a     = v.a;
      req_b     = v.b;
      @(posedge clk);
      @(negedge clk);
      req_valid   = 1'b0;
      lat         = 1;
      mul_ctl_bad = 1'b0;
      while (!rsp_valid && lat < 60) begin
         if (v.op == 3'b110 && alu_control != 3'b100) mul_ctl_bad = 1'b1;
         @(negedge clk);
         lat++;
      end
      check($sformatf("v%0d latency", idx), lat, v.lat);
      check($sformatf("v%0d rsp_data", idx), rsp_data, v.data);
      check($sformatf("v%0d rsp_carry", idx), {31'b0, rsp_carry}, {31'b0, v.carry});
      check($sformatf("v%0d rsp_err", idx), {31'b0, rsp_err}, {31'b0, v.err});
      check($sformatf("v%0d alu idle in RESP", idx), alu_a | alu_b | {29'b0, alu_control}, 32'd0);
      if (v.op == 3'b110)
         check($sformatf("v%0d mul alu_control", idx), {31'b0, mul_ctl_bad}, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check($sformatf("v%0d req_ready after rsp", idx), {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      vecs[0]  = '{3'b000, 32'h0F0F1234, 32'h00000000, 32'hF0F0EDCB, 1'b0, 1'b0, 2};
      vecs[1]  = '{3'b001, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, 2};
      vecs[2]  = '{3'b010, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, 1'b0, 2};
      vecs[3]  = '{3'b011, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0, 1'b0, 2};
      vecs[4]  = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 2};
      vecs[5]  = '{3'b101, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 2};
      vecs[6]  = '{3'b100, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 2};
      vecs[7]  = '{3'b101, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 2};
      vecs[8]  = '{3'b110, 32'h00010003, 32'h00000005, 32'h0005000F, 1'b0, 1'b0, 34};
      vecs[9]  = '{3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 34};
      vecs[10] = '{3'b110, 32'h00003039, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 34};
      vecs[11] = '{3'b111, 32'h00001234, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_valid2 = 1'b0;
      rsp_ready  = 1'b0;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      repeat (2) @(negedge clk);
      check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("reset rsp_data", rsp_data, 32'd0);
      check("reset rsp_flags", {30'b0, rsp_carry, rsp_err}, 32'd0);
      check("reset alu outputs", alu_a | alu_b | {29'b0, alu_control}, 32'd0);
      rst = 1'b0;
      check("req_ready after reset", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < 12; i++)
         run_vec(vecs[i], i);

      // Response held under backpressure.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b001; req_a = 32'hFF00FF00; req_b = 32'h0FF00FF0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold%0d data", k), rsp_data, 32'h0F000F00);
         check($sformatf("hold%0d flags", k), {29'b0, rsp_carry, rsp_err, req_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hold release req_ready", {31'b0, req_ready}, 32'd1);
      check("hold release rsp_valid", {31'b0, rsp_valid}, 32'd0);

      // Reset in the middle of a multiply.
      req_valid = 1'b1; req_op = 3'b110; req_a = 32'h00010003; req_b = 32'h00000005;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("mid-mul alu_control", {29'b0, alu_control}, 32'd4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("abort req_ready", {31'b0, req_ready}, 32'd1);
      check("abort alu outputs", alu_a | alu_b | {29'b0, alu_control}, 32'd0);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid) n++;
         @(negedge clk);
      end
      check("abort no response", n, 0);
      run_vec(vecs[6], 100);

      // Opcode 110 is illegal when multiply is disabled.
      req_valid2 = 1'b1; req_op = 3'b110; req_a = 32'h00001234; req_b = 32'h00000005;
      @(posedge clk);
      @(negedge clk);
      req_valid2 = 1'b0;
      check("nomul rsp_valid", {31'b0, rsp_valid2}, 32'd1);
      check("nomul rsp_err", {31'b0, rsp_err2}, 32'd1);
      check("nomul rsp_data", rsp_data2, 32'd0);
      check("nomul rsp_carry", {31'b0, rsp_carry2}, 32'd0);
      check("nomul alu idle", alu_a2 | alu_b2 | {29'b0, alu_control2}, 32'd0);
      @(negedge clk);
      check("nomul req_ready", {31'b0, req_ready2}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
